// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle signed restoring divider, one quotient bit per clock
// Optional: define DIV_ZERO_SKIP_EN to bypass the iteration phase when the divisor is zero.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_in_q, a_in_d;
  logic [WIDTH-1:0] b_in_q, b_in_d;
  logic [WIDTH-1:0] aq_q, aq_d;
  logic [WIDTH-1:0] b_abs_q, b_abs_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dvz_q, dvz_d;

  logic [WIDTH:0]   p_sh;
  logic             p_ge;
  logic             accept;

  // P never reaches |B| between steps, so only the shifted value needs the extra bit
  assign p_sh   = {p_q, aq_q[WIDTH-1]};
  assign p_ge   = (p_sh >= {1'b0, b_abs_q});
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_in_d      = a_in_q;
    b_in_d      = b_in_q;
    aq_d        = aq_q;
    b_abs_d     = b_abs_q;
    p_d         = p_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dvz_d       = dvz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_PREP;
          a_in_d  = dividend;
          b_in_d  = divisor;
          dvz_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        aq_d     = a_in_q[WIDTH-1] ? -a_in_q : a_in_q;
        b_abs_d  = b_in_q[WIDTH-1] ? -b_in_q : b_in_q;
        sign_q_d = a_in_q[WIDTH-1] ^ b_in_q[WIDTH-1];
        sign_r_d = a_in_q[WIDTH-1];
        p_d      = '0;
        cnt_d    = '0;
        state_d  = S_ITER;
`ifdef DIV_ZERO_SKIP_EN
        if (b_in_q == '0) state_d = S_FIX;
`else
`endif
      end
      S_ITER: begin
        p_d   = p_ge ? (p_sh[WIDTH-1:0] - b_abs_q) : p_sh[WIDTH-1:0];
        aq_d  = {aq_q[WIDTH-2:0], p_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (b_abs_q == '0) begin
          quotient_d  = '1;
          remainder_d = a_in_q;
          dvz_d       = 1'b1;
        end else begin
          quotient_d  = sign_q_q ? -aq_q : aq_q;
          remainder_d = sign_r_q ? -p_q : p_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_in_q      <= '0;
      b_in_q      <= '0;
      aq_q        <= '0;
      b_abs_q     <= '0;
      p_q         <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dvz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_in_q      <= a_in_d;
      b_in_q      <= b_in_d;
      aq_q        <= aq_d;
      b_abs_q     <= b_abs_d;
      p_q         <= p_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dvz_q       <= dvz_d;
    end
  end

  assign busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dvz_q;

endmodule
